// File: rtl/decode_stage.sv
// decode_stage: 2-entry fetch/decode FIFO with RV32I field and immediate decode.
// Define DECODE_ILLEGAL_EN to flag non-RV32I head entries on illegal.
module decode_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] pc_fetch,
  input  logic [31:0] inst_fetch,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] pc_decode,
  output logic [31:0] inst_decode,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [31:0] jal_target_decode,
  output logic        jal_taken,
  output logic        illegal
);
  logic [31:0] pc_mem [2];
  logic [31:0] inst_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        push, pop;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  assign fetch_ready = (count < 2'd2) && !reset;
  assign dec_valid   = count != 2'd0;
  assign push        = fetch_valid && fetch_ready;
  assign pop         = dec_valid && dec_ready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      pc_mem[0]   <= 32'd0;
      pc_mem[1]   <= 32'd0;
      inst_mem[0] <= NOP_INST;
      inst_mem[1] <= NOP_INST;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= pc_fetch;
        inst_mem[wr_ptr] <= inst_fetch;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign pc_decode   = pc_mem[rd_ptr];
  assign inst_decode = inst_mem[rd_ptr];
  assign opcode      = inst_decode[6:0];
  assign rd          = inst_decode[11:7];
  assign funct3      = inst_decode[14:12];
  assign rs1         = inst_decode[19:15];
  assign rs2         = inst_decode[24:20];
  assign funct7      = inst_decode[31:25];
  assign i_imm = {{20{inst_decode[31]}}, inst_decode[31:20]};
  assign s_imm = {{20{inst_decode[31]}}, inst_decode[31:25], inst_decode[11:7]};
  assign b_imm = {{19{inst_decode[31]}}, inst_decode[31], inst_decode[7], inst_decode[30:25], inst_decode[11:8], 1'b0};
  assign u_imm = {inst_decode[31:12], 12'b0};
  assign j_imm = {{11{inst_decode[31]}}, inst_decode[31], inst_decode[19:12], inst_decode[20], inst_decode[30:21], 1'b0};
  always_comb begin
    imm = (opcode == 7'b0000011 || opcode == 7'b0010011 || opcode == 7'b1100111) ? i_imm :
          (opcode == 7'b0100011) ? s_imm :
          (opcode == 7'b1100011) ? b_imm :
          (opcode == 7'b0110111 || opcode == 7'b0010111) ? u_imm :
          (opcode == 7'b1101111) ? j_imm : 32'd0;
  end
  assign jal_target_decode = pc_decode + imm;
  assign jal_taken         = dec_valid && opcode == 7'b1101111;
`ifdef DECODE_ILLEGAL_EN
  assign illegal = dec_valid && (inst_decode[1:0] != 2'b11 ||
                   !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                                    7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011}));
`else
  assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (honours DECODE_ILLEGAL_EN).
module tb_decode_stage;
  logic        clock, reset, flush, fetch_valid, fetch_ready, dec_valid, dec_ready;
  logic [31:0] pc_fetch, inst_fetch, pc_decode, inst_decode, imm, jal_target_decode;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        jal_taken, illegal;
  int          checks = 0, errors = 0;
  logic [63:0] sb_q [$];

  decode_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .pc_fetch(pc_fetch), .inst_fetch(inst_fetch),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .pc_decode(pc_decode), .inst_decode(inst_decode),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .jal_target_decode(jal_target_decode), .jal_taken(jal_taken), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_imm(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67: return 32'($signed(w[31:20]));
      7'h23: return 32'($signed({w[31:25], w[11:7]}));
      7'h63: return 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      7'h37, 7'h17: return w & 32'hFFFF_F000;
      7'h6F: return 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
`ifdef DECODE_ILLEGAL_EN
    logic [4:0] op;
    op = w[6:2];
    return !(w[1:0] == 2'b11 && op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                                           5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100});
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: queue depth is the FIFO occupancy, front is the head entry.
  always @(negedge clock) begin
    if (reset) begin
      sb_q.delete();
      check("rst_dec_valid", 32'(dec_valid), 32'd0);
      check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
      check("rst_jal_taken", 32'(jal_taken), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
    end else begin
      check("dec_valid", 32'(dec_valid), 32'(sb_q.size() != 0));
      check("fetch_ready", 32'(fetch_ready), 32'(sb_q.size() < 2));
      if (dec_valid && sb_q.size() != 0) begin
        logic [31:0] epc, ein;
        {epc, ein} = sb_q[0];
        check("pc_decode", pc_decode, epc);
        check("inst_decode", inst_decode, ein);
        check("fields", {opcode, rd, funct3, rs1, rs2, funct7[6:0]} , {ein[6:0], ein[11:7], ein[14:12], ein[19:15], ein[24:20], ein[31:25]});
        check("imm", imm, exp_imm(ein));
        check("jal_target", jal_target_decode, epc + exp_imm(ein));
        check("jal_taken", 32'(jal_taken), 32'(ein[6:0] == 7'h6F));
        check("illegal", 32'(illegal), 32'(exp_illegal(ein)));
      end
      if (flush)
        sb_q.delete();
      else begin
        if (dec_valid && dec_ready && sb_q.size() != 0)
          void'(sb_q.pop_front());
        if (fetch_valid && fetch_ready)
          sb_q.push_back({pc_fetch, inst_fetch});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] in);
    fetch_valid = v;
    pc_fetch    = pc;
    inst_fetch  = in;
  endtask

  initial begin
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F, 7'h10};
    reset = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(fetch_ready), 32'd1);
    // addi x1,x0,5
    dec_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h0050_0093);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("addi_valid", 32'(dec_valid), 32'd1);
    check("addi_rd", 32'(rd), 32'd1);
    check("addi_rs1", 32'(rs1), 32'd0);
    check("addi_imm", imm, 32'd5);
    step();
    @(negedge clock);
    check("addi_drained", 32'(dec_valid), 32'd0);
    // fill, third pair stalls, then drain in order
    dec_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h0000_0013);
    step();
    drive(1'b1, 32'h300, 32'h0010_0093);
    step();
    drive(1'b1, 32'h500, 32'h0010_0113);
    @(negedge clock);
    check("full_ready", 32'(fetch_ready), 32'd0);
    check("full_head", pc_decode, 32'h200);
    step();
    @(negedge clock);
    check("full_hold", pc_decode, 32'h200);
    dec_ready = 1'b1;
    step();
    @(negedge clock);
    check("order_2", pc_decode, 32'h300);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("order_3", pc_decode, 32'h500);
    step();
    @(negedge clock);
    check("order_empty", 32'(dec_valid), 32'd0);
    // beq x0,x0,-4
    dec_ready = 1'b0;
    drive(1'b1, 32'h400, 32'hFE00_0EE3);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("beq_imm", imm, 32'hFFFF_FFFC);
    check("beq_jal", 32'(jal_taken), 32'd0);
    dec_ready = 1'b1;
    step();
    // jal +8 wrapping past the top of the address space
    dec_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFC, 32'h0080_006F);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("jal_taken_d", 32'(jal_taken), 32'd1);
    check("jal_target_d", jal_target_decode, 32'h0000_0004);
    dec_ready = 1'b1;
    step();
    // flush while full with a pair presented
    dec_ready = 1'b0;
    drive(1'b1, 32'h600, 32'h0000_0013);
    step();
    drive(1'b1, 32'h700, 32'h0000_0013);
    step();
    drive(1'b1, 32'h800, 32'h0000_0013);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("flush_valid", 32'(dec_valid), 32'd0);
    check("flush_ready", 32'(fetch_ready), 32'd1);
    // flush while empty drops the presented pair
    drive(1'b1, 32'h880, 32'h0000_0013);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 32'h900, 32'h0000_0013);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("after_flush_head", pc_decode, 32'h900);
    dec_ready = 1'b1;
    step();
    // illegal opcode
    dec_ready = 1'b0;
    drive(1'b1, 32'hA00, 32'h0000_007F);
    step();
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
`ifdef DECODE_ILLEGAL_EN
    check("illegal_7f", 32'(illegal), 32'd1);
`else
    check("illegal_7f", 32'(illegal), 32'd0);
`endif
    dec_ready = 1'b1;
    step();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      drive(1'($urandom_range(0, 1)), $urandom(), {r[31:7], ops[$urandom_range(0, 11)]});
      dec_ready = 1'($urandom_range(0, 2) != 0);
      flush = $urandom_range(0, 24) == 0;
      step();
    end
    // asynchronous reset mid-operation
    flush = 1'b0;
    dec_ready = 1'b0;
    drive(1'b1, 32'hB00, 32'h0000_0013);
    repeat (2) step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(dec_valid), 32'd0);
    check("async_rst_ready", 32'(fetch_ready), 32'd0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("ready_after_rst2", 32'(fetch_ready), 32'd1);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
